// File: rtl/mul_seq_ctrl_if.sv
// Request/result handshake plus the borrowed ALU port for the multiply sequencer.
// master = requester/ALU side, slave = sequencer; no backpressure, start is a level sampled when idle.
interface mul_seq_ctrl_if;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [2:0]  alu_ctrl;
  logic [15:0] alu_dport1;
  logic [15:0] alu_dport2;
  logic [15:0] alu_out;

  modport master (
    output start, op_a, op_b, alu_out,
    input  busy, done, product, ovf, alu_ctrl, alu_dport1, alu_dport2
  );

  modport slave (
    input  start, op_a, op_b, alu_out,
    output busy, done, product, ovf, alu_ctrl, alu_dport1, alu_dport2
  );
endinterface

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add 16x16->16 multiply driven through the shared ALU, one ALU op per cycle.
// Latency 3k cycles (k = multiplier bit length, min 1); start is ignored while busy, no backpressure.
module mul_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLA = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD,
    S_SHL,
    S_SHR,
    S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] acc, acc_nxt;
  logic [15:0] mcand, mcand_nxt;
  logic [15:0] mplier, mplier_nxt;
  logic        ovf_r, ovf_nxt;
  logic        accept;

  assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      ovf_r  <= 1'b0;
    end else begin
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      ovf_r  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    acc_nxt        = acc;
    mcand_nxt      = mcand;
    mplier_nxt     = mplier;
    ovf_nxt        = ovf_r;
    bus.alu_ctrl   = ALU_ADD;
    bus.alu_dport1 = '0;
    bus.alu_dport2 = '0;
    bus.busy       = 1'b0;
    bus.done       = 1'b0;

    if (accept) begin
      acc_nxt    = '0;
      mcand_nxt  = bus.op_a;
      mplier_nxt = bus.op_b;
      ovf_nxt    = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_ADD;
      end
      S_ADD: begin
        bus.busy       = 1'b1;
        bus.alu_ctrl   = ALU_ADD;
        bus.alu_dport1 = acc;
        bus.alu_dport2 = mcand;
        if (mplier[0]) begin
          acc_nxt = bus.alu_out;
          // Unsigned wrap shows up as a sum smaller than the addend.
          if (bus.alu_out < acc) ovf_nxt = 1'b1;
        end
        state_nxt = S_SHL;
      end
      S_SHL: begin
        bus.busy       = 1'b1;
        bus.alu_ctrl   = ALU_SLA;
        bus.alu_dport1 = mcand;
        mcand_nxt      = bus.alu_out;
        // A set bit falling off the multiplicand matters only if more multiplier bits remain.
        if (mcand[15] && (mplier[15:1] != 15'd0)) ovf_nxt = 1'b1;
        state_nxt = S_SHR;
      end
      S_SHR: begin
        bus.busy       = 1'b1;
        bus.alu_ctrl   = ALU_SRA;
        bus.alu_dport1 = mplier;
        mplier_nxt     = bus.alu_out;
        state_nxt      = (bus.alu_out == 16'd0) ? S_DONE : S_ADD;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = accept ? S_ADD : S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.product = acc;
  assign bus.ovf     = ovf_r;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl with a behavioural ALU closing the combinational loop.
module tb_mul_seq_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  mul_seq_ctrl_if bus ();

  mul_seq_ctrl dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.alu_out = 16'h0000;
    case (bus.alu_ctrl)
      3'b000:  bus.alu_out = bus.alu_dport1 + bus.alu_dport2;
      3'b110:  bus.alu_out = {bus.alu_dport1[14:0], 1'b0};
      3'b111:  bus.alu_out = {1'b0, bus.alu_dport1[15:1]};
      default: bus.alu_out = 16'h0000;
    endcase
  end

  // Starts at a negedge, returns at the negedge where done is seen (or after the timeout).
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int exp_lat,
                        input logic [15:0] exp_p, input logic exp_ovf, input bit inject,
                        input bit check_seq, input bit hold_done, input string nm);
    int n = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int seq_err = 0;
    logic [2:0] exp_ctrl;
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.done) break;
      if (cyc == 0) begin
        checks++;
        if (bus.product !== 16'h0 || bus.ovf !== 1'b0 || bus.alu_dport2 !== a) begin
          failures++;
          $display("FAIL %s first_add: product=%h ovf=%b dport2=%h expected 0000/0/%h",
                   nm, bus.product, bus.ovf, bus.alu_dport2, a);
        end
      end
      if (bus.busy) busy_cnt++;
      if (check_seq) begin
        exp_ctrl = (cyc % 3 == 0) ? 3'b000 : ((cyc % 3 == 1) ? 3'b110 : 3'b111);
        if (bus.alu_ctrl !== exp_ctrl) seq_err++;
      end
      if (inject && cyc == 10) begin
        bus.start = 1'b1;
        bus.op_a  = 16'h0002;
        bus.op_b  = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      cyc++;
      @(posedge clk);
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (bus.done !== 1'b1) begin
      failures++;
      $display("FAIL %s done_timeout: done=%b after %0d edges, expected done at %0d",
               nm, bus.done, n, exp_lat);
      return;
    end
    checks++;
    if (n != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d edges expected %0d", nm, n, exp_lat);
    end
    checks++;
    if (busy_cnt != exp_lat) begin
      failures++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", nm, busy_cnt, exp_lat);
    end
    checks++;
    if (bus.product !== exp_p || bus.ovf !== exp_ovf) begin
      failures++;
      $display("FAIL %s result: product=%h ovf=%b expected %h/%b",
               nm, bus.product, bus.ovf, exp_p, exp_ovf);
    end
    if (check_seq) begin
      checks++;
      if (seq_err != 0) begin
        failures++;
        $display("FAIL %s alu_sequence: %0d wrong opcodes expected 0", nm, seq_err);
      end
    end
    if (!hold_done) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.product !== exp_p || bus.ovf !== exp_ovf) begin
        failures++;
        $display("FAIL %s after_done: done=%b busy=%b product=%h ovf=%b expected 0/0/%h/%b",
                 nm, bus.done, bus.busy, bus.product, bus.ovf, exp_p, exp_ovf);
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.op_a  = 16'h0;
    bus.op_b  = 16'h0;
    rst_n     = 1'b0;
    #2;
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.alu_ctrl, bus.product, bus.alu_dport1, bus.alu_dport2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b ctrl=%b product=%h d1=%h d2=%h expected all 0",
               bus.busy, bus.done, bus.ovf, bus.alu_ctrl, bus.product, bus.alu_dport1, bus.alu_dport2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.alu_ctrl, bus.product, bus.alu_dport1, bus.alu_dport2} !== '0) begin
      failures++;
      $display("FAIL idle_outputs: busy=%b done=%b ctrl=%b product=%h expected all 0",
               bus.busy, bus.done, bus.alu_ctrl, bus.product);
    end
  endtask

  task automatic test_reset_midrun();
    bus.start = 1'b1;
    bus.op_a  = 16'h0003;
    bus.op_b  = 16'h0007;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.alu_ctrl !== 3'b110 || bus.product !== 16'h0003 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrun_shl: ctrl=%b product=%h busy=%b expected 110/0003/1",
               bus.alu_ctrl, bus.product, bus.busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.alu_ctrl, bus.product, bus.alu_dport1, bus.alu_dport2} !== '0) begin
      failures++;
      $display("FAIL midrun_reset: busy=%b done=%b ctrl=%b product=%h d1=%h expected all 0",
               bus.busy, bus.done, bus.alu_ctrl, bus.product, bus.alu_dport1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_idle: busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    run_op(16'h0003, 16'h0007, 9, 16'h0015, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset_3x7");
  endtask

  task automatic test_basic();
    run_op(16'h0003, 16'h0005, 9, 16'h000F, 1'b0, 1'b0, 1'b1, 1'b0, "basic_3x5");
  endtask

  task automatic test_zero_mult();
    run_op(16'h1234, 16'h0000, 3, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, "zero_mplier");
  endtask

  task automatic test_back_to_back();
    run_op(16'h00FF, 16'h0101, 27, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, "b2b_first");
    run_op(16'h0100, 16'h0100, 27, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_max_inject();
    run_op(16'hFFFF, 16'hFFFF, 48, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0, "max_inject");
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_basic();
    test_zero_mult();
    test_back_to_back();
    test_max_inject();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Multi-cycle unsigned 16x16->16 multiply sequencer for the non-pipelined core. It runs shift-and-add multiplication by driving the combinational ALU's control and data ports through a state machine, one ALU operation per cycle, using only the ALU's ADD, SLA and SRA operations. It sits beside the execute stage and takes the ALU through a mux while busy. It reports the low 16 bits of the product, an overflow flag and a start/busy/done handshake.

## Interface
- No parameters; datapath width fixed at 16, ALU opcodes fixed: ADD=3'b000, SLA=3'b110, SRA=3'b111 (SRA is a logical right shift by 1).
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- start  in  1  request a multiply; sampled only in IDLE or DONE
- op_a  in  16  multiplicand, sampled with start
- op_b  in  16  multiplier, sampled with start
- alu_out  in  16  result from the ALU, same-cycle (combinational) return
- alu_ctrl  out  3  ALU operation select
- alu_dport1  out  16  ALU operand 1
- alu_dport2  out  16  ALU operand 2
- busy  out  1  high while in ADD/SHL/SHR
- done  out  1  one-cycle pulse, high in DONE
- product  out  16  accumulator; valid from done until the next accepted start
- ovf  out  1  sticky: true product exceeded 16 bits; valid with product

## Operation
- Internal registers: acc, mcand, mplier (16 bits each), ovf_r, and a state register with IDLE, ADD, SHL, SHR, DONE.
- Reset (async, rst_n low): state=IDLE, acc=mcand=mplier=0, ovf_r=0; all outputs 0 (alu_ctrl=3'b000, dports 0, busy=0, done=0, product=0, ovf=0).
- IDLE and DONE accept start. On acceptance: mcand<=op_a, mplier<=op_b, acc<=0, ovf_r<=0, ->ADD. DONE->IDLE when start is low.
- ADD: alu_ctrl=ADD, dport1=acc, dport2=mcand.
  - If mplier[0]=1: acc<=alu_out, and ovf_r<=1 when alu_out<acc (unsigned wrap).
  - If mplier[0]=0: acc holds.
  - Next state SHL.
- SHL: alu_ctrl=SLA, dport1=mcand, dport2=0; mcand<=alu_out. ovf_r<=1 if mcand[15]=1 and mplier[15:1]!=0. ->SHR.
- SHR: alu_ctrl=SRA, dport1=mplier, dport2=0; mplier<=alu_out. ->DONE if alu_out==0, else ->ADD.
- IDLE/DONE ALU drive: alu_ctrl=3'b000, dport1=dport2=0.
- ALU outputs are Moore, decoded from the state and registers only, so the ALU result returns in the same cycle.
- Loop termination:
  - The loop ends on the first SHR that produces mplier==0.
  - No iteration counter is needed: 16 shifts always clear mplier.
  - op_b=0 still runs one full iteration.
- Arithmetic is modulo 2^16. product=acc and ovf=ovf_r, driven directly from the registers.
- start in ADD/SHL/SHR is ignored. Operands cannot change mid-operation.

## Timing
- Let k = (index of highest set bit of op_b)+1, and k=1 when op_b=0.
- Edge 0 samples start. busy is high after edge 0 through edge 3k-1. done is high for exactly one cycle after edge 3k. Total latency is 3k cycles, from 3 to 48.
- product and ovf are stable from the done cycle until the edge that accepts the next start. At that edge they clear to 0.
- Back-to-back: start high during DONE is accepted. The next ADD follows immediately, with no IDLE cycle.
- rst_n asserted mid-operation: immediate return to IDLE with all outputs 0. The operation is abandoned and no done pulse occurs.
- rst_n deassertion takes effect at the next rising edge; start is first sampled there.

## Test plan
- Reset mid-run: assert rst_n low during SHL of a 0x0003*0x0007 run -> all outputs 0 asynchronously, state IDLE; a new 0x0003*0x0007 start then gives product=0x0015 with done 9 edges later.
- op_a=0x0003, op_b=0x0005 -> ALU sequence ADD,SLA,SRA x3; done 9 edges after start; product=0x000F, ovf=0; busy high for exactly 9 cycles.
- op_a=0x1234, op_b=0x0000 -> one iteration, done after 3 edges, product=0x0000, ovf=0.
- op_a=0x00FF, op_b=0x0101 -> done after 27 edges, product=0xFFFF, ovf=0. Then issue 0x0100*0x0100 back-to-back in the DONE cycle -> product=0x0000, ovf=1.
- op_a=0xFFFF, op_b=0xFFFF -> done after 48 edges, product=0x0001, ovf=1. A start pulse injected mid-run is ignored, and product is unchanged.
